// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage ALU with single-cycle logic/arithmetic ops and
// iterative radix-2 multiply (and optionally divide/remainder) behind a
// start/done handshake. Define ALU_MULDIV_DIV_EN to build the divider;
// without it, opcodes 12/13 complete in one cycle with result 0.
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [3:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] ALU_Result_o,
    output logic             Zero_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_reg, state_next;
    logic [SHAMT_W-1:0]   cnt_reg;
    logic [3:0]           op_reg;
    logic                 a_neg_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [2*WIDTH-1:0]   prod_reg;
    logic [WIDTH-1:0]     result_reg;
    logic                 zero_reg;
`ifdef ALU_MULDIV_DIV_EN
    logic [WIDTH-1:0]     a_reg;
`endif

    logic                 accept;
    logic                 iter_in;
    logic [WIDTH-1:0]     single_result;
    logic [WIDTH-1:0]     a_mag_in;
    logic                 b_neg;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   step_next;
    logic [2*WIDTH-1:0]   prod_signed;
    logic [WIDTH-1:0]     iter_result;
`ifdef ALU_MULDIV_DIV_EN
    logic                 op_div;
    logic [WIDTH:0]       r_shift;
    logic                 r_ge;
    logic [WIDTH-1:0]     r_new;
    logic [WIDTH-1:0]     div_q;
    logic [WIDTH-1:0]     div_r;
`endif

    assign accept   = (state_reg == IDLE) && start_i;
    // Both the multiplier and the dividend start out as |A| in the low half.
    assign a_mag_in = A_i[WIDTH-1] ? -A_i : A_i;
    assign b_neg    = b_reg[WIDTH-1];
    assign b_mag    = b_neg ? -b_reg : b_reg;

`ifdef ALU_MULDIV_DIV_EN
    assign iter_in = (ALU_Operation_i >= 4'd10) && (ALU_Operation_i <= 4'd13);
    assign op_div  = (op_reg == 4'd12) || (op_reg == 4'd13);
`else
    assign iter_in = (ALU_Operation_i == 4'd10) || (ALU_Operation_i == 4'd11);
`endif

    // Single-cycle datapath; unlisted opcodes (and disabled DIV/REM) give 0.
    always_comb begin
        single_result = '0;
        case (ALU_Operation_i)
            4'd0:    single_result = A_i + B_i;
            4'd1:    single_result = A_i - B_i;
            4'd2:    single_result = A_i | B_i;
            4'd3:    single_result = A_i & B_i;
            4'd4:    single_result = A_i ^ B_i;
            4'd5:    single_result = B_i << 12;
            4'd6:    single_result = A_i << B_i[SHAMT_W-1:0];
            4'd7:    single_result = A_i >> B_i[SHAMT_W-1:0];
            4'd8:    single_result = B_i - A_i;
            4'd9:    single_result = WIDTH'(A_i == B_i);
            4'd15:   single_result = A_i + (B_i << 12);
            default: single_result = '0;
        endcase
    end

    // One radix-2 step: shift-add on magnitudes for MUL/MULH, restoring
    // division for DIV/REM (upper half = partial remainder, lower = quotient).
    always_comb begin
        mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, b_mag} : '0);
        step_next = {mul_sum, prod_reg[WIDTH-1:1]};
`ifdef ALU_MULDIV_DIV_EN
        r_shift = prod_reg[2*WIDTH-1:WIDTH-1];
        r_ge    = (r_shift >= {1'b0, b_mag});
        // When the subtract is skipped r_shift < |B| <= 2^(WIDTH-1), so its MSB is 0.
        r_new   = r_ge ? WIDTH'(r_shift - {1'b0, b_mag}) : r_shift[WIDTH-1:0];
        if (op_div) begin
            step_next = {r_new, prod_reg[WIDTH-2:0], r_ge};
        end
`endif
    end

    // Sign correction applied to the value produced by the final step.
    always_comb begin
        prod_signed = (a_neg_reg ^ b_neg) ? -step_next : step_next;
        iter_result = '0;
`ifdef ALU_MULDIV_DIV_EN
        div_q = step_next[WIDTH-1:0];
        div_r = step_next[2*WIDTH-1:WIDTH];
`endif
        case (op_reg)
            4'd10:   iter_result = prod_signed[WIDTH-1:0];
            4'd11:   iter_result = prod_signed[2*WIDTH-1:WIDTH];
`ifdef ALU_MULDIV_DIV_EN
            // Divide by zero: quotient all ones, remainder is the dividend.
            4'd12:   iter_result = (b_reg == '0) ? '1 : ((a_neg_reg ^ b_neg) ? -div_q : div_q);
            4'd13:   iter_result = (b_reg == '0) ? a_reg : (a_neg_reg ? -div_r : div_r);
`endif
            default: iter_result = '0;
        endcase
    end

    // State, operand latches, iteration register and registered result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            op_reg     <= '0;
            a_neg_reg  <= 1'b0;
            b_reg      <= '0;
            prod_reg   <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b1;
`ifdef ALU_MULDIV_DIV_EN
            a_reg      <= '0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg    <= ALU_Operation_i;
                a_neg_reg <= A_i[WIDTH-1];
                b_reg     <= B_i;
                prod_reg  <= {{WIDTH{1'b0}}, a_mag_in};
                cnt_reg   <= SHAMT_W'(WIDTH - 1);
`ifdef ALU_MULDIV_DIV_EN
                a_reg     <= A_i;
`endif
                if (!iter_in) begin
                    result_reg <= single_result;
                    zero_reg   <= (single_result == '0);
                end
            end else if (state_reg == CALC) begin
                prod_reg <= step_next;
                cnt_reg  <= cnt_reg - SHAMT_W'(1);
                if (cnt_reg == '0) begin
                    result_reg <= iter_result;
                    zero_reg   <= (iter_result == '0);
                end
            end
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state_reg;
        ready_o    = 1'b0;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_o = 1'b1;
                busy_o  = 1'b0;
                if (start_i) state_next = iter_in ? CALC : DONE;
            end
            CALC: begin
                if (cnt_reg == '0) state_next = DONE;
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ALU_Result_o = result_reg;
    assign Zero_o       = zero_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle (WIDTH=32). Divider vectors are
// selected by ALU_MULDIV_DIV_EN, matching the build of the design.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  alu_op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        ready_o, busy_o, done_o, zero_o;
    logic [31:0] result_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start),
        .ALU_Operation_i (alu_op),
        .A_i             (a_in),
        .B_i             (b_in),
        .ready_o         (ready_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .ALU_Result_o    (result_o),
        .Zero_o          (zero_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
        $fatal(1, "timeout");
    end

    // Issue one op once idle; operands are scrambled right after accept.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic z);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        alu_op = op; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a_in = $urandom; b_in = $urandom; alu_op = 4'($urandom);
        lat = 1;
        while (!done_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done_o) lat = -1;
        res = result_o;
        z   = zero_o;
    endtask

    task automatic test_reset;
        int lat; logic [31:0] res; logic z; bit no_done;
        reset = 1'b1; start = 1'b0; alu_op = '0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done_o); end
        tests++; if (result_o !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 00000000", result_o); end
        tests++; if (zero_o !== 1'b1) begin fails++; $display("FAIL reset_zero: got %b want 1", zero_o); end
        @(negedge clk); reset = 1'b0;
        // Give the result register a nonzero value, then reset mid-MUL.
        run_op(4'd0, 32'd1, 32'd2, lat, res, z);
        tests++; if (res !== 32'd3) begin fails++; $display("FAIL pre_reset_add: got %h want 00000003", res); end
        @(negedge clk);
        while (!ready_o) @(negedge clk);
        alu_op = 4'd10; a_in = 32'hFFFFFFFD; b_in = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        #1;
        $display("[TB] reset mid-CALC: ready=%b busy=%b done=%b result=%h zero=%b", ready_o, busy_o, done_o, result_o, zero_o);
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL midcalc_ready: got %b want 1", ready_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL midcalc_busy: got %b want 0", busy_o); end
        tests++; if (result_o !== 32'h0) begin fails++; $display("FAIL midcalc_result: got %h want 00000000", result_o); end
        tests++; if (zero_o !== 1'b1) begin fails++; $display("FAIL midcalc_zero: got %b want 1", zero_o); end
        @(negedge clk); reset = 1'b0;
        no_done = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done_o !== 1'b0 || ready_o !== 1'b1) no_done = 1'b0;
        end
        tests++; if (no_done !== 1'b1) begin fails++; $display("FAIL midcalc_discarded: got done/busy after reset, want idle with no done"); end
    endtask

    task automatic run_table(input string tag);
        int lat; logic [31:0] res; logic z;
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, z);
            $display("[TB] %s %s op=%0d a=%h b=%h -> result=%h zero=%b lat=%0d",
                     tag, vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat);
            tests++; if (res !== vecs[i].exp) begin fails++; $display("FAIL %s_result: got %h want %h", vecs[i].name, res, vecs[i].exp); end
            tests++; if (z !== (vecs[i].exp == 32'h0)) begin fails++; $display("FAIL %s_zero: got %b want %b", vecs[i].name, z, (vecs[i].exp == 32'h0)); end
            tests++; if (lat != vecs[i].lat) begin fails++; $display("FAIL %s_latency: got %0d want %0d", vecs[i].name, lat, vecs[i].lat); end
        end
    endtask

    task automatic test_single_cycle;
        vecs.delete();
        vecs.push_back('{"add_zero",  4'd0,  32'd5,        32'hFFFFFFFB, 32'h00000000, 1});
        vecs.push_back('{"sub",       4'd1,  32'd3,        32'd5,        32'hFFFFFFFE, 1});
        vecs.push_back('{"or",        4'd2,  32'h000000F0, 32'h0000000F, 32'h000000FF, 1});
        vecs.push_back('{"and",       4'd3,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1});
        vecs.push_back('{"xor",       4'd4,  32'h000000FF, 32'h0000000F, 32'h000000F0, 1});
        vecs.push_back('{"lui",       4'd5,  32'hDEADBEEF, 32'd1,        32'h00001000, 1});
        vecs.push_back('{"sll_33",    4'd6,  32'd1,        32'd33,       32'h00000002, 1});
        vecs.push_back('{"srl_31",    4'd7,  32'h80000000, 32'd31,       32'h00000001, 1});
        vecs.push_back('{"srl_36",    4'd7,  32'h00000100, 32'd36,       32'h00000010, 1});
        vecs.push_back('{"beq",       4'd8,  32'd3,        32'd10,       32'h00000007, 1});
        vecs.push_back('{"bne_eq",    4'd9,  32'd7,        32'd7,        32'h00000001, 1});
        vecs.push_back('{"bne_ne",    4'd9,  32'd7,        32'd8,        32'h00000000, 1});
        vecs.push_back('{"auipc",     4'd15, 32'h00000100, 32'd2,        32'h00002100, 1});
        vecs.push_back('{"add_pos",   4'd0,  32'd40,       32'd2,        32'h0000002A, 1});
        vecs.push_back('{"op14",      4'd14, 32'd5,        32'd5,        32'h00000000, 1});
        run_table("single");
    endtask

    task automatic test_muldiv;
        vecs.delete();
        vecs.push_back('{"mul_neg",    4'd10, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 33});
        vecs.push_back('{"mulh_min2",  4'd11, 32'h80000000, 32'd2,        32'hFFFFFFFF, 33});
        vecs.push_back('{"mul_10x2",   4'd10, 32'd10,       32'd2,        32'd20,       33});
        vecs.push_back('{"mulh_m1m1",  4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
        vecs.push_back('{"mulh_max",   4'd11, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 33});
        vecs.push_back('{"mul_wrap",   4'd10, 32'h00010000, 32'h00010000, 32'h00000000, 33});
`ifdef ALU_MULDIV_DIV_EN
        vecs.push_back('{"div_m7_2",   4'd12, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
        vecs.push_back('{"rem_m7_2",   4'd13, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
        vecs.push_back('{"div_by0",    4'd12, 32'd5,        32'd0,        32'hFFFFFFFF, 33});
        vecs.push_back('{"rem_by0",    4'd13, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 33});
        vecs.push_back('{"div_min_m1", 4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
        vecs.push_back('{"rem_min_m1", 4'd13, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33});
        vecs.push_back('{"div_100_m7", 4'd12, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33});
        vecs.push_back('{"rem_100_m7", 4'd13, 32'd100,      32'hFFFFFFF9, 32'h00000002, 33});
`else
        vecs.push_back('{"div_off",    4'd12, 32'd10,       32'd2,        32'h00000000, 1});
        vecs.push_back('{"mul_mid",    4'd10, 32'd6,        32'd7,        32'd42,       33});
        vecs.push_back('{"rem_off",    4'd13, 32'd7,        32'd2,        32'h00000000, 1});
`endif
        run_table("muldiv");
    endtask

    task automatic test_back_to_back;
        int lat; int cyc; logic [31:0] res; logic z; bit held_ok;
        run_op(4'd0, 32'd100, 32'd23, lat, res, z);
        tests++; if (res !== 32'd123) begin fails++; $display("FAIL b2b_setup: got %h want 0000007b", res); end
        @(negedge clk);
        while (!ready_o) @(negedge clk);
        alu_op = 4'd10; a_in = 32'd6; b_in = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        alu_op = 4'd0; a_in = 32'd1; b_in = 32'd1;
        cyc = 1; held_ok = 1'b1;
        while (!done_o && cyc < 100) begin
            if (result_o !== 32'd123 || ready_o !== 1'b0) held_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        $display("[TB] b2b mul 6*7 with start held -> result=%h lat=%0d", result_o, cyc);
        tests++; if (held_ok !== 1'b1) begin fails++; $display("FAIL b2b_held: result/ready changed while busy, want result 0000007b and ready 0"); end
        tests++; if (cyc != 33) begin fails++; $display("FAIL b2b_latency: got %0d want 33", cyc); end
        tests++; if (result_o !== 32'd42) begin fails++; $display("FAIL b2b_mul_result: got %h want 0000002a", result_o); end
        @(posedge clk); #1;
        tests++; if (ready_o !== 1'b1 || done_o !== 1'b0 || result_o !== 32'd42) begin
            fails++; $display("FAIL b2b_idle_gap: got ready=%b done=%b result=%h want ready=1 done=0 result=0000002a", ready_o, done_o, result_o);
        end
        @(posedge clk); #1;
        $display("[TB] b2b add 1+1 accepted after idle -> done=%b result=%h", done_o, result_o);
        tests++; if (done_o !== 1'b1 || result_o !== 32'd2) begin
            fails++; $display("FAIL b2b_second_op: got done=%b result=%h want done=1 result=00000002", done_o, result_o);
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
